// File: rtl/touch_hold_pkg.sv
// Shared types and constants for the touch hold sequencer: FSM states, quadrant code,
// colour counter reset values and count directions.
package touch_hold_pkg;

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HOLD} state_t;

   typedef logic [1:0] area_t;

   // Index [q] holds quadrant q; q0/q3 count up, q1/q2 count down.
   localparam logic [3:0][2:0] COUNT_RESET = {3'd0, 3'd7, 3'd7, 3'd0};
   localparam logic [3:0]      COUNT_DIR   = 4'b1001;

   // Bit 0 is the X half, bit 1 the Y half; equal to the split goes high side.
   function automatic area_t decode_area(input logic [11:0] x, input logic [11:0] y,
                                         input logic [11:0] split);
      return {(y >= split), (x >= split)};
   endfunction

endpackage

// File: rtl/bcd4_sat_counter.sv
// Four-digit BCD up-counter saturating at 9999; Clear wins over Inc, one-cycle update.
// No backpressure: Inc is a single-cycle request honoured on the same edge.
module bcd4_sat_counter (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Clear,
   input  logic        Inc,
   output logic [15:0] Bcd
);

   logic [15:0] bcd_next;
   logic        carry;

   always_comb begin
      bcd_next = Bcd;
      carry    = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (Bcd[d*4 +: 4] == 4'd9) begin
               bcd_next[d*4 +: 4] = 4'd0;
            end else begin
               bcd_next[d*4 +: 4] = Bcd[d*4 +: 4] + 4'd1;
               carry              = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn || Clear) begin
         Bcd <= 16'h0000;
      end else if (Inc && (Bcd != 16'h9999)) begin
         Bcd <= bcd_next;
      end
   end

endmodule

// File: rtl/touch_hold_sequencer.sv
// Debounces the touched quadrant, then emits a hold step every HOLD_MS; step is registered
// one cycle after the qualifying ms tick, counters one cycle later. No backpressure.
module touch_hold_sequencer
   import touch_hold_pkg::*;
#(
   parameter int CLK_PER_MS  = 50000,
   parameter int HOLD_MS     = 1000,
   parameter int DEBOUNCE_MS = 20,
   parameter int SPLIT       = 2048
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Touch_En,
   input  logic        Coord_En,
   input  logic [11:0] X_Coord,
   input  logic [11:0] Y_Coord,
   output logic [1:0]  Area_code,
   output logic        Area_valid,
   output logic        Step_pulse,
   output logic [11:0] Count_q,
   output logic [2:0]  Max_count,
   output logic [15:0] Timer_bcd
);

   localparam int PW = $clog2(CLK_PER_MS);
   localparam int DW = $clog2(DEBOUNCE_MS + 1);
   localparam int HW = $clog2(HOLD_MS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_MS - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
   localparam logic [11:0]   SPLIT_C    = 12'(SPLIT);

   state_t           state, next_state;
   logic [PW-1:0]    presc;
   logic [DW-1:0]    deb_cnt;
   logic [HW-1:0]    hold_cnt;
   logic [11:0]      x_reg, y_reg;
   logic [3:0][2:0]  cnt;
   logic [2:0]       max_next;
   area_t            in_area, cand_area;
   logic             ms_tick, touch_start, rearm, arm_hold, step_now;

   // in_area judges a coordinate on its strobe cycle, cand_area is the armed (latched) one.
   assign in_area     = decode_area(X_Coord, Y_Coord, SPLIT_C);
   assign cand_area   = decode_area(x_reg, y_reg, SPLIT_C);
   assign ms_tick     = (state != S_IDLE) && (presc == PRESC_LAST);
   assign touch_start = (state == S_IDLE) && Touch_En && Coord_En;

   always_ff @(posedge Clock) begin
      if (!Resetn) state <= S_IDLE;
      else         state <= next_state;
   end

   // Release beats area change beats a completing tick.
   always_comb begin
      next_state = state;
      rearm      = 1'b0;
      arm_hold   = 1'b0;
      step_now   = 1'b0;
      case (state)
         S_IDLE: begin
            if (Touch_En && Coord_En) next_state = S_DEBOUNCE;
         end
         S_DEBOUNCE: begin
            if (!Touch_En) begin
               next_state = S_IDLE;
            end else if (Coord_En && (in_area != cand_area)) begin
               rearm = 1'b1;
            end else if (ms_tick && (deb_cnt == DEB_LAST)) begin
               next_state = S_HOLD;
               arm_hold   = 1'b1;
            end
         end
         S_HOLD: begin
            if (!Touch_En) begin
               next_state = S_IDLE;
            end else if (Coord_En && (in_area != Area_code)) begin
               next_state = S_DEBOUNCE;
            end else if (ms_tick && (hold_cnt == HOLD_LAST)) begin
               step_now = 1'b1;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         presc      <= '0;
         deb_cnt    <= '0;
         hold_cnt   <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         Area_code  <= '0;
         Area_valid <= 1'b0;
         Step_pulse <= 1'b0;
      end else begin
         Step_pulse <= step_now;
         if (Coord_En) begin
            x_reg <= X_Coord;
            y_reg <= Y_Coord;
         end
         if ((next_state != state) || ms_tick || (state == S_IDLE)) presc <= '0;
         else                                                      presc <= presc + PW'(1);
         if (((next_state == S_DEBOUNCE) && (state != S_DEBOUNCE)) || rearm)
            deb_cnt <= '0;
         else if ((state == S_DEBOUNCE) && (next_state == S_DEBOUNCE) && ms_tick)
            deb_cnt <= deb_cnt + DW'(1);
         if (arm_hold || step_now)
            hold_cnt <= '0;
         else if ((state == S_HOLD) && (next_state == S_HOLD) && ms_tick)
            hold_cnt <= hold_cnt + HW'(1);
         if (arm_hold) begin
            Area_code  <= cand_area;
            Area_valid <= 1'b1;
         end else if ((state == S_HOLD) && (next_state != S_HOLD)) begin
            Area_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         cnt <= COUNT_RESET;
      end else if (Step_pulse) begin
         if (COUNT_DIR[Area_code]) cnt[Area_code] <= cnt[Area_code] + 3'd1;
         else                      cnt[Area_code] <= cnt[Area_code] - 3'd1;
      end
   end

   always_comb begin
      max_next = cnt[0];
      for (int i = 1; i < 4; i++) begin
         if (cnt[i] > max_next) max_next = cnt[i];
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) Max_count <= 3'd7;
      else         Max_count <= max_next;
   end

   assign Count_q = cnt;

   bcd4_sat_counter u_timer (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Clear  (touch_start),
      .Inc    (ms_tick),
      .Bcd    (Timer_bcd)
   );

endmodule
